// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and types for the data-memory arbiter: state encoding,
// port indices and datapath widths.
package dmem_arbiter_pkg;

  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 8;
  localparam int BURST_W_DEF = 4;

  localparam int PORT0 = 0;
  localparam int PORT1 = 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-request round-robin picker: combinational pick, registered pointer
// remembering which port won most recently.
module rr_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] pick
);

  logic last_q, last_d;

  always_comb begin
    pick   = 2'b00;
    last_d = last_q;
    if (en) begin
      // On a tie, the port that did not win last time goes first.
      if (req[PORT0] && req[PORT1]) pick = last_q ? 2'b01 : 2'b10;
      else                          pick = req;
      if (pick[PORT0])      last_d = 1'b0;
      else if (pick[PORT1]) last_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= 1'b1;
    else      last_q <= last_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the MEM stage (port 0, single
// beats) and a DMA/debug master (port 1, auto-incrementing bursts).
//
// state    | meaning
// ST_IDLE  | arbitrate; port 0 beat, port 1 single beat or burst beat 0
// ST_BURST | port 1 beats 1..N at incrementing addresses, port 0 held off
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               we0,
  input  logic [ADDR_W-1:0]  addr0,
  input  logic [DATA_W-1:0]  wdata0,
  output logic               gnt0,
  output logic               rvalid0,
  output logic [DATA_W-1:0]  rdata0,
  input  logic               req1,
  input  logic               we1,
  input  logic [ADDR_W-1:0]  addr1,
  input  logic [DATA_W-1:0]  wdata1,
  input  logic [BURST_W-1:0] len1,
  output logic               gnt1,
  output logic               rvalid1,
  output logic [DATA_W-1:0]  rdata1,
  output logic               busy1,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [DATA_W-1:0]  mem_write_data,
  output logic               mem_read_write,
  input  logic [DATA_W-1:0]  mem_read_data
);

  logic [0:0]         state_q, state_d;
  addr_t              bst_addr_q, bst_addr_d;
  logic               bst_we_q, bst_we_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  addr_t              mem_addr_q, mem_addr_d;
  logic               rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  data_t              rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic               arb_en;
  logic [1:0]         pick;

  // Grants are suppressed while reset is held so nothing reaches memory.
  assign arb_en = rst && (state_q == ST_IDLE);

  rr_pick2 u_pick (
    .clk  (clk),
    .rst  (rst),
    .req  ({req1, req0}),
    .en   (arb_en),
    .pick (pick)
  );

  always_comb begin
    state_d        = state_q;
    bst_addr_d     = bst_addr_q;
    bst_we_d       = bst_we_q;
    rem_d          = rem_q;
    mem_addr_d     = mem_addr_q;
    rvalid0_d      = 1'b0;
    rvalid1_d      = 1'b0;
    rdata0_d       = rdata0_q;
    rdata1_d       = rdata1_q;
    gnt0           = 1'b0;
    gnt1           = 1'b0;
    busy1          = 1'b0;
    mem_address    = mem_addr_q;
    mem_write_data = wdata0;
    mem_read_write = 1'b0;
    if (state_q == ST_IDLE) begin
      if (pick[PORT0]) begin
        gnt0           = 1'b1;
        mem_address    = addr0;
        mem_write_data = wdata0;
        mem_read_write = we0;
        rvalid0_d      = !we0;
      end else if (pick[PORT1]) begin
        gnt1           = 1'b1;
        mem_address    = addr1;
        mem_write_data = wdata1;
        mem_read_write = we1;
        rvalid1_d      = !we1;
        if (len1 != '0) begin
          busy1      = 1'b1;
          state_d    = ST_BURST;
          bst_addr_d = addr1 + 8'd1;
          bst_we_d   = we1;
          rem_d      = len1;
        end
      end
    end else begin
      busy1 = 1'b1;
      if (req1) begin
        gnt1           = 1'b1;
        mem_address    = bst_addr_q;
        mem_write_data = wdata1;
        mem_read_write = bst_we_q;
        rvalid1_d      = !bst_we_q;
        bst_addr_d     = bst_addr_q + 8'd1;
        rem_d          = rem_q - 1'b1;
        if (rem_d == '0) state_d = ST_IDLE;
      end else begin
        state_d = ST_IDLE;
        rem_d   = '0;
      end
    end
    if (gnt0 || gnt1) mem_addr_d = mem_address;
    if (rvalid0_d)    rdata0_d   = mem_read_data;
    if (rvalid1_d)    rdata1_d   = mem_read_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      bst_addr_q <= '0;
      bst_we_q   <= 1'b0;
      rem_q      <= '0;
      mem_addr_q <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      bst_addr_q <= bst_addr_d;
      bst_we_q   <= bst_we_d;
      rem_q      <= rem_d;
      mem_addr_q <= mem_addr_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a vector table for single-cycle behaviour
// plus hand sequences for bursts, abort and mid-burst reset.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [7:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic [3:0] len1 = '0;
  logic       gnt0, rvalid0, gnt1, rvalid1, busy1, mem_read_write;
  logic [7:0] rdata0, rdata1, mem_address, mem_write_data, mem_read_data;
  logic       load_en = 1'b1;
  logic [7:0] mem [256];

  int total = 0;
  int bad   = 0;
  int beats;

  always #5 clk = ~clk;

  dmem_arbiter #(.BURST_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .len1(len1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .busy1(busy1),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_write(mem_read_write), .mem_read_data(mem_read_data)
  );

  // Data memory: combinational read, write on the rising edge.
  assign mem_read_data = mem[mem_address];
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
      mem[8'h40] <= 8'h0A;
      mem[8'h41] <= 8'h0B;
      mem[8'h42] <= 8'h0C;
    end else if (mem_read_write) begin
      mem[mem_address] <= mem_write_data;
    end
  end

  typedef struct {
    logic       req0, we0;
    logic [7:0] addr0, wdata0;
    logic       req1, we1;
    logic [7:0] addr1, wdata1;
    logic [3:0] len1;
    logic       g0, g1, mrw, busy;
    logic [7:0] maddr;
    logic       rv0;
    logic [7:0] rd0;
    logic       rv1;
    logic [7:0] rd1;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(input int r0, w0, a0, d0, r1, w1, a1, d1, l1,
                              g0, g1, mrw, busy, maddr, rv0, rd0, rv1, rd1);
    vec_t v;
    v.req0 = 1'(r0); v.we0 = 1'(w0); v.addr0 = 8'(a0); v.wdata0 = 8'(d0);
    v.req1 = 1'(r1); v.we1 = 1'(w1); v.addr1 = 8'(a1); v.wdata1 = 8'(d1);
    v.len1 = 4'(l1);
    v.g0 = 1'(g0); v.g1 = 1'(g1); v.mrw = 1'(mrw); v.busy = 1'(busy);
    v.maddr = 8'(maddr);
    v.rv0 = 1'(rv0); v.rd0 = 8'(rd0); v.rv1 = 1'(rv1); v.rd1 = 8'(rd1);
    return v;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r0, w0, input logic [7:0] a0, d0,
                       input logic r1, w1, input logic [7:0] a1, d1,
                       input logic [3:0] l1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; len1 = l1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          r0 w0 a0    d0    r1 w1 a1    d1 l1  g0 g1 mrw bsy maddr rv0 rd0   rv1 rd1
    vecs[0]  = mk(1, 0, 20,   0,    1, 0, 30,   0, 0,  1, 0, 0, 0, 20,   0, 0,    0, 0);
    vecs[1]  = mk(1, 0, 20,   0,    1, 0, 30,   0, 0,  0, 1, 0, 0, 30,   1, 20,   0, 0);
    vecs[2]  = mk(1, 0, 20,   0,    1, 0, 30,   0, 0,  1, 0, 0, 0, 20,   0, 20,   1, 30);
    vecs[3]  = mk(1, 0, 20,   0,    1, 0, 30,   0, 0,  0, 1, 0, 0, 30,   1, 20,   0, 30);
    vecs[4]  = mk(1, 1, 100,  'h5A, 0, 0, 0,    0, 0,  1, 0, 1, 0, 100,  0, 20,   1, 30);
    vecs[5]  = mk(1, 0, 100,  0,    0, 0, 0,    0, 0,  1, 0, 0, 0, 100,  0, 20,   0, 30);
    vecs[6]  = mk(0, 0, 0,    0,    0, 0, 0,    0, 0,  0, 0, 0, 0, 100,  1, 'h5A, 0, 30);
    vecs[7]  = mk(0, 0, 0,    0,    0, 0, 0,    0, 0,  0, 0, 0, 0, 100,  0, 'h5A, 0, 30);
    vecs[8]  = mk(0, 0, 0,    0,    1, 0, 'h40, 0, 2,  0, 1, 0, 1, 'h40, 0, 'h5A, 0, 30);
    vecs[9]  = mk(0, 0, 0,    0,    1, 0, 'h40, 0, 2,  0, 1, 0, 1, 'h41, 0, 'h5A, 1, 'h0A);
    vecs[10] = mk(0, 0, 0,    0,    1, 0, 'h40, 0, 2,  0, 1, 0, 1, 'h42, 0, 'h5A, 1, 'h0B);
    vecs[11] = mk(0, 0, 0,    0,    0, 0, 0,    0, 0,  0, 0, 0, 0, 'h42, 0, 'h5A, 1, 'h0C);
    vecs[12] = mk(0, 0, 0,    0,    0, 0, 0,    0, 0,  0, 0, 0, 0, 'h42, 0, 'h5A, 0, 'h0C);

    // Reset with requests pending: nothing may be granted or written.
    drive(1, 1, 8'h33, 8'h99, 1, 1, 8'h34, 8'h98, 4'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    load_en = 1'b0;
    chk1("rst gnt0", gnt0, 1'b0);
    chk1("rst gnt1", gnt1, 1'b0);
    chk1("rst mem_rw", mem_read_write, 1'b0);
    chk8("rst mem_addr", mem_address, 8'h00);
    chk1("rst busy1", busy1, 1'b0);
    chk8("rst rdata0", rdata0, 8'h00);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    next_cycle();

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].req0, vecs[i].we0, vecs[i].addr0, vecs[i].wdata0,
            vecs[i].req1, vecs[i].we1, vecs[i].addr1, vecs[i].wdata1, vecs[i].len1);
      @(negedge clk);
      chk1($sformatf("v%0d gnt0", i), gnt0, vecs[i].g0);
      chk1($sformatf("v%0d gnt1", i), gnt1, vecs[i].g1);
      chk1($sformatf("v%0d mem_rw", i), mem_read_write, vecs[i].mrw);
      chk1($sformatf("v%0d busy1", i), busy1, vecs[i].busy);
      chk8($sformatf("v%0d mem_addr", i), mem_address, vecs[i].maddr);
      chk1($sformatf("v%0d rvalid0", i), rvalid0, vecs[i].rv0);
      chk8($sformatf("v%0d rdata0", i), rdata0, vecs[i].rd0);
      chk1($sformatf("v%0d rvalid1", i), rvalid1, vecs[i].rv1);
      chk8($sformatf("v%0d rdata1", i), rdata1, vecs[i].rd1);
      next_cycle();
    end

    // Write burst of 4 at 0xFE wrapping to 0x01; port 0 waits it out.
    drive(0, 0, 8'h05, 0, 1, 1, 8'hFE, 8'd1, 4'd3);
    @(negedge clk);
    chk1("wb0 gnt1", gnt1, 1'b1);
    chk1("wb0 busy1", busy1, 1'b1);
    chk8("wb0 addr", mem_address, 8'hFE);
    chk1("wb0 mem_rw", mem_read_write, 1'b1);
    next_cycle();
    for (int k = 1; k <= 3; k++) begin
      req0 = 1'b1;
      wdata1 = 8'(k + 1);
      @(negedge clk);
      chk1($sformatf("wb%0d gnt1", k), gnt1, 1'b1);
      chk1($sformatf("wb%0d gnt0", k), gnt0, 1'b0);
      chk1($sformatf("wb%0d busy1", k), busy1, 1'b1);
      chk8($sformatf("wb%0d addr", k), mem_address, 8'(8'hFE + k));
      chk1($sformatf("wb%0d mem_rw", k), mem_read_write, 1'b1);
      next_cycle();
    end
    req1 = 1'b0;
    @(negedge clk);
    chk1("wb5 gnt0", gnt0, 1'b1);
    chk1("wb5 gnt1", gnt1, 1'b0);
    chk1("wb5 busy1", busy1, 1'b0);
    chk8("wb5 addr", mem_address, 8'h05);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk8("mem[FE]", mem[8'hFE], 8'd1);
    chk8("mem[FF]", mem[8'hFF], 8'd2);
    chk8("mem[00]", mem[8'h00], 8'd3);
    chk8("mem[01]", mem[8'h01], 8'd4);
    chk1("wb rvalid0", rvalid0, 1'b1);
    chk8("wb rdata0", rdata0, 8'h05);
    next_cycle();

    // Read burst of 6 at 0x80 abandoned after two beats.
    beats = 0;
    drive(0, 0, 8'h07, 0, 1, 0, 8'h80, 0, 4'd5);
    @(negedge clk);
    beats += int'(gnt1);
    chk8("ab0 addr", mem_address, 8'h80);
    next_cycle();
    req0 = 1'b1;
    @(negedge clk);
    beats += int'(gnt1);
    chk1("ab1 gnt0", gnt0, 1'b0);
    chk8("ab1 addr", mem_address, 8'h81);
    next_cycle();
    req1 = 1'b0;
    @(negedge clk);
    beats += int'(gnt1);
    chk1("ab2 gnt0", gnt0, 1'b0);
    chk1("ab2 mem_rw", mem_read_write, 1'b0);
    chk1("ab2 rvalid1", rvalid1, 1'b1);
    chk8("ab2 rdata1", rdata1, 8'h81);
    next_cycle();
    @(negedge clk);
    beats += int'(gnt1);
    chk1("ab3 gnt0", gnt0, 1'b1);
    chk1("ab3 busy1", busy1, 1'b0);
    chk8("ab3 addr", mem_address, 8'h07);
    chk1("ab3 rvalid1", rvalid1, 1'b0);
    chk8("ab beats", 8'(beats), 8'd2);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk8("ab rdata0", rdata0, 8'h07);
    next_cycle();

    // Reset asserted in the middle of a write burst at 0x10.
    drive(0, 0, 8'h03, 0, 1, 1, 8'h10, 8'hEE, 4'd7);
    next_cycle();
    req0 = 1'b1;
    next_cycle();
    #2;
    rst = 1'b0;
    #1;
    chk1("mr gnt0", gnt0, 1'b0);
    chk1("mr gnt1", gnt1, 1'b0);
    chk1("mr busy1", busy1, 1'b0);
    chk1("mr mem_rw", mem_read_write, 1'b0);
    chk8("mr addr", mem_address, 8'h00);
    chk1("mr rvalid0", rvalid0, 1'b0);
    chk8("mr rdata0", rdata0, 8'h00);
    chk8("mr rdata1", rdata1, 8'h00);
    @(posedge clk);
    @(negedge clk);
    chk8("mr mem[11]", mem[8'h11], 8'hEE);
    chk8("mr mem[12]", mem[8'h12], 8'h12);
    drive(1, 0, 8'h03, 0, 1, 0, 8'h04, 0, 4'd0);
    rst = 1'b1;
    #1;
    chk1("post gnt0", gnt0, 1'b1);
    chk1("post gnt1", gnt1, 1'b0);
    next_cycle();
    @(negedge clk);
    chk1("post2 gnt1", gnt1, 1'b1);
    chk8("post2 addr", mem_address, 8'h04);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
